output_collector: RTL and testbench
===================================

OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 Param ROWS, default 4, PE rows.
REQ-002 Param COLS, default 4, PE columns.
REQ-003 Param NUM_CH, default 64; CH_BITS = $clog2(NUM_CH+1).
REQ-004 Param MAX_N, default 512; N_BITS = $clog2(MAX_N+1).
REQ-005 Param ACC_W, default 32, PE accumulator width.
REQ-006 Param FIFO_DEPTH, default 16, power of two, at least 8; HI_WM = FIFO_DEPTH-4.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 Ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- in_valid  in  [ROWS*COLS]x1  per-PE result valid
- in_row  in  [ROWS*COLS]xN_BITS  output row
- in_col  in  [ROWS*COLS]xN_BITS  output col
- in_sum  in  [ROWS*COLS]xACC_W  PE accumulator
- in_channel  in  CH_BITS  channel of the active block
- wr_ready  in  1  sink accepts
- wr_valid  out  1  write entry valid
- wr_row  out  N_BITS  entry row
- wr_col  out  N_BITS  entry col
- wr_ch  out  CH_BITS  entry channel
- wr_data  out  ACC_W  entry value
- stall_req  out  1  upstream stall request
- overflow  out  1  sticky drop error
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy

Function
REQ-009 Per-PE capture slot k holds {row, col, ch, sum} and a pending bit; in_valid[k]=1 at edge t loads the slot and sets pending at t+1.
REQ-010 in_valid[k] while slot k is pending and not granted in that cycle: keep the old contents, drop the new data, set overflow.
REQ-011 in_valid[k] in the same cycle slot k is granted: the grant takes the old data, and the slot reloads with the new data and stays pending.
REQ-012 Arbiter: at most one grant per cycle, only when the FIFO is not full or is popping that cycle.
REQ-013 Grant order is round-robin: search starts at last_grant+1 modulo ROWS*COLS; last_grant resets to ROWS*COLS-1, so slot 0 has first priority.
REQ-014 A granted slot writes to the FIFO at that edge and its pending bit clears unless REQ-011 applies.
REQ-015 The FIFO is show-ahead: wr_* reflect the head entry, and wr_valid = (fifo_count != 0).
REQ-016 Pop on wr_valid && wr_ready; wr_* stay stable while wr_valid && !wr_ready.
REQ-017 Push and pop in the same cycle leave the count unchanged; a push at full is impossible by REQ-012.
REQ-018 Minimum latency: in_valid at edge t, grant in cycle t+1, wr_valid in cycle t+2.
REQ-019 stall_req is registered: 1 when next fifo_count >= HI_WM or next pending-slot count > COLS, otherwise 0.
REQ-020 Pointers wrap modulo FIFO_DEPTH; fifo_count saturates at neither 0 nor FIFO_DEPTH because of REQ-012 and REQ-016.
REQ-021 wr_ch holds in_channel as sampled at capture; no arithmetic is applied to in_sum.

Reset
REQ-022 Reset clears all pending bits, FIFO pointers, fifo_count, overflow and stall_req, and sets last_grant to ROWS*COLS-1.
REQ-023 Reset mid-operation discards all pending and FIFO contents; wr_valid is 0 in the first cycle after reset.
REQ-024 overflow clears only on reset.

Structure
REQ-025 The entry struct {row, col, ch, data} and the HI_WM derivation live in sys_types.svh.
REQ-026 The FIFO is one sub-module, sync_fifo, parameterized by width and depth; the arbiter stays inline.

Verification
REQ-027 Single in_valid[0] with row=5, col=7, ch=3, sum=0x1234 and wr_ready=1 -> wr_valid only in cycle t+2 carrying 5/7/3/0x1234; fifo_count returns to 0.
REQ-028 All 16 in_valid in one cycle with wr_ready=1 -> 16 writes on consecutive cycles in slot order 0..15; stall_req=1 while pending > 4; no overflow.
REQ-029 wr_ready=0 with 16 entries fed -> fifo_count stops at 16; wr_* stable; stall_req=1 from count 12; releasing wr_ready drains all 16 in order.
REQ-030 in_valid[3] twice while slot 3 is blocked -> overflow=1; the first value is delivered and the second is dropped.
REQ-031 Grant and re-capture of slot 2 in the same cycle -> both values are delivered, old then new.
REQ-032 Reset asserted with 5 FIFO entries and 3 pending slots -> the next cycle shows wr_valid=0, fifo_count=0, stall_req=0, overflow=0.

Source files
------------

// File: rtl/output_collector_pkg.sv
// Shared constants and elaboration helpers for the output collector and its FIFO.
package output_collector_pkg;

  localparam int unsigned FIFO_MIN_DEPTH = 8;
  localparam int unsigned HI_WM_MARGIN   = 4;

  function automatic int unsigned calc_hi_wm(input int unsigned depth);
    return depth - HI_WM_MARGIN;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_collector_sync_fifo.sv
// Show-ahead synchronous FIFO: data_o always presents the head entry.
module sync_fifo
  import output_collector_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam int AW = safe_clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/output_collector.sv
// Collects per-PE results into capture slots and serialises them round-robin into a show-ahead FIFO.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int NUM_CH     = 64,
  parameter int MAX_N      = 512,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_BITS   = $clog2(NUM_CH + 1),
  localparam int N_BITS    = $clog2(MAX_N + 1),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ROWS*COLS-1:0]                 in_valid,
  input  logic [ROWS*COLS-1:0][N_BITS-1:0]     in_row,
  input  logic [ROWS*COLS-1:0][N_BITS-1:0]     in_col,
  input  logic [ROWS*COLS-1:0][ACC_W-1:0]      in_sum,
  input  logic [CH_BITS-1:0]                   in_channel,
  input  logic                                 wr_ready,
  output logic                                 wr_valid,
  output logic [N_BITS-1:0]                    wr_row,
  output logic [N_BITS-1:0]                    wr_col,
  output logic [CH_BITS-1:0]                   wr_ch,
  output logic [ACC_W-1:0]                     wr_data,
  output logic                                 stall_req,
  output logic                                 overflow,
  output logic [CNT_W-1:0]                     fifo_count
);

  localparam int NPE   = ROWS * COLS;
  localparam int IDX_W = safe_clog2(NPE);
  localparam int HI_WM = calc_hi_wm(FIFO_DEPTH);

  typedef struct packed {
    logic [N_BITS-1:0]  row;
    logic [N_BITS-1:0]  col;
    logic [CH_BITS-1:0] ch;
    logic [ACC_W-1:0]   data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [NPE-1:0]              pend_q, pend_d;
  logic [NPE-1:0]              load, drop, granted;
  logic [NPE-1:0][ENTRY_W-1:0] slot_bus;
  logic [IDX_W-1:0]            last_grant_q, grant_idx;
  logic                        grant_vld, can_grant, fifo_full, pop;
  logic                        overflow_q, overflow_d;
  logic                        stall_q, stall_d;
  logic [CNT_W-1:0]            count_nxt;
  logic [ENTRY_W-1:0]          head;
  entry_t                      head_e;

  assign pop       = wr_valid && wr_ready;
  assign can_grant = !fifo_full || pop;

  // Round-robin search beginning one past the most recent grant.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    cand      = last_grant_q;
    if (can_grant) begin
      for (int i = 1; i <= NPE; i++) begin
        cand = IDX_W'((int'(last_grant_q) + i) % NPE);
        if (!grant_vld && pend_q[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // A slot may reload in the cycle it is granted; otherwise a busy slot drops new data.
  for (genvar k = 0; k < NPE; k++) begin : g_slot
    entry_t slot_q;

    assign granted[k]  = grant_vld && (grant_idx == IDX_W'(k));
    assign load[k]     = in_valid[k] && (!pend_q[k] || granted[k]);
    assign drop[k]     = in_valid[k] && pend_q[k] && !granted[k];
    assign pend_d[k]   = load[k] || (pend_q[k] && !granted[k]);
    assign slot_bus[k] = slot_q;

    always_ff @(posedge clk) begin
      if (load[k]) begin
        slot_q <= '{row: in_row[k], col: in_col[k], ch: in_channel, data: in_sum[k]};
      end
    end
  end

  assign overflow_d = overflow_q || (|drop);
  assign count_nxt  = fifo_count + CNT_W'(grant_vld) - CNT_W'(pop);
  assign stall_d    = (count_nxt >= CNT_W'(HI_WM)) || ($countones(pend_d) > COLS);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      last_grant_q <= IDX_W'(NPE - 1);
      overflow_q   <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      if (grant_vld) begin
        last_grant_q <= grant_idx;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (grant_vld),
    .data_i  (slot_bus[grant_idx]),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  assign head_e    = entry_t'(head);
  assign wr_valid  = (fifo_count != '0);
  assign wr_row    = head_e.row;
  assign wr_col    = head_e.col;
  assign wr_ch     = head_e.ch;
  assign wr_data   = head_e.data;
  assign stall_req = stall_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: vector table plus scoreboard-checked multi-cycle sequences.
module tb_output_collector;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int NUM_CH     = 64;
  localparam int MAX_N      = 512;
  localparam int ACC_W      = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int NPE        = ROWS * COLS;
  localparam int IW         = $clog2(NPE);
  localparam int CH_BITS    = $clog2(NUM_CH + 1);
  localparam int N_BITS     = $clog2(MAX_N + 1);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic [NPE-1:0]                in_valid;
  logic [NPE-1:0][N_BITS-1:0]    in_row, in_col;
  logic [NPE-1:0][ACC_W-1:0]     in_sum;
  logic [CH_BITS-1:0]            in_channel;
  logic                          wr_ready;
  logic                          wr_valid;
  logic [N_BITS-1:0]             wr_row, wr_col;
  logic [CH_BITS-1:0]            wr_ch;
  logic [ACC_W-1:0]              wr_data;
  logic                          stall_req, overflow;
  logic [CNT_W-1:0]              fifo_count;

  typedef struct packed {
    logic [N_BITS-1:0]  row;
    logic [N_BITS-1:0]  col;
    logic [CH_BITS-1:0] ch;
    logic [ACC_W-1:0]   data;
  } ent_t;

  typedef struct {
    int   slot;
    ent_t stim;
    ent_t exp;
  } vec_t;

  ent_t sb[$];
  int   total = 0;
  int   bad = 0;

  output_collector #(
    .ROWS(ROWS), .COLS(COLS), .NUM_CH(NUM_CH), .MAX_N(MAX_N),
    .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_row(in_row),
    .in_col(in_col), .in_sum(in_sum), .in_channel(in_channel),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_row(wr_row),
    .wr_col(wr_col), .wr_ch(wr_ch), .wr_data(wr_data),
    .stall_req(stall_req), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input int r, input int c, input int ch, input logic [ACC_W-1:0] d);
    ent_t e;
    e.row  = N_BITS'(r);
    e.col  = N_BITS'(c);
    e.ch   = CH_BITS'(ch);
    e.data = d;
    return e;
  endfunction

  task automatic load_slot(input logic [IW-1:0] k, input ent_t e);
    in_row[k]   = e.row;
    in_col[k]   = e.col;
    in_sum[k]   = e.data;
    in_channel  = e.ch;
    in_valid[k] = 1'b1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while ((sb.size() != 0 || fifo_count != '0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, 64'((sb.size() == 0) && (fifo_count == '0)), 64'd1);
  endtask

  // Scoreboard: every accepted write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 64'd1, 64'd0);
      end else begin
        ent_t exp;
        exp = sb.pop_front();
        check("sb_entry", 64'({wr_row, wr_col, wr_ch, wr_data}), 64'(exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    ent_t e, a, b, head0;

    vecs[0] = '{slot: 1,  stim: mk(0, 0, 0, 32'h0),          exp: mk(0, 0, 0, 32'h0)};
    vecs[1] = '{slot: 5,  stim: mk(512, 512, 64, 32'hFFFFFFFF), exp: mk(512, 512, 64, 32'hFFFFFFFF)};
    vecs[2] = '{slot: 15, stim: mk(1, 2, 3, 32'h80000000),    exp: mk(1, 2, 3, 32'h80000000)};
    vecs[3] = '{slot: 8,  stim: mk(100, 200, 10, 32'h1),      exp: mk(100, 200, 10, 32'h1)};
    vecs[4] = '{slot: 0,  stim: mk(511, 0, 63, 32'h7FFFFFFF), exp: mk(511, 0, 63, 32'h7FFFFFFF)};
    vecs[5] = '{slot: 12, stim: mk(3, 9, 1, 32'hDEADBEEF),    exp: mk(3, 9, 1, 32'hDEADBEEF)};

    in_valid = '0; in_row = '0; in_col = '0; in_sum = '0; in_channel = '0; wr_ready = 1'b1;
    do_reset();
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Single capture: minimum latency and payload.
    e = mk(5, 7, 3, 32'h1234);
    load_slot(0, e);
    sb.push_back(e);
    @(negedge clk); check("lat_c0_valid", 64'(wr_valid), 64'd0);
    @(posedge clk); #1; in_valid = '0;
    @(negedge clk); check("lat_c1_valid", 64'(wr_valid), 64'd0);
    @(negedge clk); check("lat_c2_valid", 64'(wr_valid), 64'd1);
    check("lat_c2_entry", 64'({wr_row, wr_col, wr_ch, wr_data}), 64'(e));
    @(negedge clk); check("lat_c3_valid", 64'(wr_valid), 64'd0);
    check("lat_c3_count", 64'(fifo_count), 64'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      load_slot(IW'(vecs[v].slot), vecs[v].stim);
      sb.push_back(vecs[v].exp);
      @(posedge clk); #1; in_valid = '0;
      wait_drain(12, "vec_drain");
      check("vec_overflow", 64'(overflow), 64'd0);
    end

    // All slots at once with a free-running sink.
    do_reset();
    wr_ready = 1'b1;
    for (int k = 0; k < NPE; k++) begin
      e = mk(k, 15 - k, 5, 32'hA000 + 32'(k));
      load_slot(IW'(k), e);
      sb.push_back(e);
    end
    @(posedge clk); #1; in_valid = '0;
    for (int m = 1; m <= 18; m++) begin
      @(negedge clk);
      check("burst_stall", 64'(stall_req), 64'((17 - m) > 4));
      check("burst_valid", 64'(wr_valid), 64'(m >= 2 && m <= 17));
    end
    @(posedge clk); #1;
    check("burst_overflow", 64'(overflow), 64'd0);
    wait_drain(10, "burst_drain");

    // Blocked sink: fill, hold, then overflow slot 3 while full.
    do_reset();
    wr_ready = 1'b0;
    for (int k = 0; k < NPE; k++) begin
      e = mk(k + 20, k + 40, 9, 32'hC000 + 32'(k));
      load_slot(IW'(k), e);
      sb.push_back(e);
    end
    head0 = mk(20, 40, 9, 32'hC000);
    @(posedge clk); #1; in_valid = '0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      check("full_count", 64'(fifo_count), 64'((m < 2) ? 0 : ((m - 1 > 16) ? 16 : m - 1)));
      check("full_stall", 64'(stall_req), 64'd1);
      if (m >= 2) check("full_head_stable", 64'({wr_row, wr_col, wr_ch, wr_data}), 64'(head0));
    end
    @(posedge clk); #1;
    a = mk(3, 3, 11, 32'h1111_0001);
    b = mk(4, 4, 12, 32'h2222_0002);
    load_slot(3, a);
    sb.push_back(a);
    @(posedge clk); #1;
    load_slot(3, b);
    @(posedge clk); #1; in_valid = '0;
    @(negedge clk);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(fifo_count), 64'd16);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    wait_drain(40, "full_drain");
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("drain_stall", 64'(stall_req), 64'd0);

    // Reset with five queued entries and three pending slots.
    wr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = mk(k, k, 2, 32'h5000 + 32'(k));
      load_slot(IW'(k), e);
      sb.push_back(e);
    end
    @(posedge clk); #1; in_valid = '0;
    for (int m = 1; m <= 6; m++) @(negedge clk);
    check("pre_rst_count", 64'(fifo_count), 64'd5);
    check("pre_rst_overflow", 64'(overflow), 64'd1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_valid", 64'(wr_valid), 64'd0);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_stall", 64'(stall_req), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_count", 64'(fifo_count), 64'd0);
    check("post_rst_valid", 64'(wr_valid), 64'd0);

    // Grant and re-capture of slot 2 in the same cycle.
    a = mk(2, 2, 6, 32'hAAAA);
    b = mk(2, 3, 7, 32'hBBBB);
    load_slot(2, a);
    sb.push_back(a);
    @(posedge clk); #1;
    load_slot(2, b);
    sb.push_back(b);
    @(posedge clk); #1; in_valid = '0;
    wait_drain(12, "regrant_drain");
    check("regrant_overflow", 64'(overflow), 64'd0);

    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
